// File: rtl/digit_serial_adder_subtractor.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock, LSB digit first,
// with a sticky carry flag for ADC/SBB chaining and valid/ready handshakes.
module digit_serial_adder_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_adder_subtractor: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic             c_q, carry_q, ovf_q, zero_q, neg_q;

    logic             accept;
    logic [WIDTH-1:0] b_d, r_d;
    logic             cin_d, ovf_d;
    logic [DIGIT:0]   sum;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept   = in_valid && in_ready;
        b_d      = op[0] ? ~b : b;
        cin_d    = op[1] ? carry_q : op[0];
        sum      = {1'b0, a_q[int'(cnt_q)*DIGIT +: DIGIT]}
                 + {1'b0, b_q[int'(cnt_q)*DIGIT +: DIGIT]}
                 + {{DIGIT{1'b0}}, c_q};
        r_d      = r_q;
        r_d[int'(cnt_q)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
        // Carry into the MSB recovered from the MSB sum bit: cin = a ^ b ^ s.
        ovf_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ r_d[WIDTH-1] ^ sum[DIGIT];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_d;
            c_q     <= cin_d;
            cnt_q   <= '0;
            state_q <= RUN;
        end else if (state_q == RUN) begin
            r_q   <= r_d;
            c_q   <= sum[DIGIT];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_q <= DONE;
                carry_q <= sum[DIGIT];
                ovf_q   <= ovf_d;
                zero_q  <= (r_d == '0);
                neg_q   <= r_d[WIDTH-1];
            end
        end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
        end
    end

    assign out_valid = (state_q == DONE);
    assign r         = r_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_digit_serial_adder_subtractor.sv
// Directed bench for digit_serial_adder_subtractor: three instances with
// DIGIT = 2, 1 and 8 (WIDTH = 8), driven from a vector table plus hand sequences.
module tb_digit_serial_adder_subtractor;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_s  [3];
    logic       in_ready_s  [3];
    logic [1:0] op_s        [3];
    logic [7:0] a_s         [3];
    logic [7:0] b_s         [3];
    logic       out_valid_s [3];
    logic       out_ready_s [3];
    logic [7:0] r_s         [3];
    logic       carry_s     [3];
    logic       overflow_s  [3];
    logic       zero_s      [3];
    logic       negative_s  [3];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
        digit_serial_adder_subtractor #(.WIDTH(8), .DIGIT(D)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .op        (op_s[g]),
            .a         (a_s[g]),
            .b         (b_s[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .r         (r_s[g]),
            .carry     (carry_s[g]),
            .overflow  (overflow_s[g]),
            .zero      (zero_s[g]),
            .negative  (negative_s[g])
        );
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] cvzn;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags(input int k);
        return {carry_s[k], overflow_s[k], zero_s[k], negative_s[k]};
    endfunction

    // Entered at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input int k, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid_s[k] = 1'b1;
        op_s[k] = o;
        a_s[k] = x;
        b_s[k] = y;
        #1 check("in_ready_before_accept", 32'(in_ready_s[k]), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid_s[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int edges);
        edges = 0;
        while (!out_valid_s[k] && edges < 40) begin
            @(posedge clock);
            @(negedge clock);
            edges++;
        end
        if (!out_valid_s[k]) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handoff(input int k);
        out_ready_s[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready_s[k] = 1'b0;
        check("out_valid_after_handoff", 32'(out_valid_s[k]), 32'd0);
    endtask

    initial begin
        int n;
        int steps [3];
        steps[0] = 4;
        steps[1] = 8;
        steps[2] = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid_s[k] = 1'b0;
            out_ready_s[k] = 1'b0;
            op_s[k] = OP_ADD;
            a_s[k] = 8'h00;
            b_s[k] = 8'h00;
        end

        //            op      a      b      r      {c,v,z,n}
        vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101};
        vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1010};
        vecs[2]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1100};
        vecs[3]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0001};
        vecs[4]  = '{OP_SBB, 8'h00, 8'h00, 8'hFF, 4'b0001};
        vecs[5]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010};
        vecs[6]  = '{OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000};
        vecs[7]  = '{OP_ADD, 8'h3C, 8'h25, 8'h61, 4'b0000};
        vecs[8]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 4'b1110};
        vecs[9]  = '{OP_ADC, 8'h01, 8'h01, 8'h03, 4'b0000};
        vecs[10] = '{OP_SBB, 8'h10, 8'h01, 8'h0E, 4'b1000};

        // Reset state, with in_ready already high while reset is held.
        #2;
        for (int k = 0; k < 3; k++) begin
            check("reset_out_valid", 32'(out_valid_s[k]), 32'd0);
            check("reset_r_flags", {19'd0, r_s[k], flags(k)}, 32'd0);
            check("reset_in_ready", 32'(in_ready_s[k]), 32'd1);
        end
        @(negedge clock);
        reset = 1'b0;

        // Table-driven sequence on the DIGIT=2 instance; the carry flag chains through.
        for (int i = 0; i < 11; i++) begin
            issue(0, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(0, n);
            check($sformatf("vec%0d_latency", i), 32'(n), 32'(steps[0]));
            check($sformatf("vec%0d_r", i), 32'(r_s[0]), 32'(vecs[i].r));
            check($sformatf("vec%0d_cvzn", i), 32'(flags(0)), 32'(vecs[i].cvzn));
            handoff(0);
        end

        // Idle after handoff keeps r and flags.
        @(negedge clock);
        check("idle_hold_r_flags", {20'd0, r_s[0], flags(0)}, {20'd0, 8'h0E, 4'b1000});

        // Back-to-back ADC held through DONE, accepted on the out_ready cycle.
        for (int k = 0; k < 3; k++) begin
            issue(k, OP_ADD, 8'hFF, 8'h01);
            wait_valid(k, n);
            check($sformatf("b2b%0d_first_latency", k), 32'(n), 32'(steps[k]));
            check($sformatf("b2b%0d_first", k), {20'd0, r_s[k], carry_s[k], 3'd0}, {20'd0, 8'h00, 1'b1, 3'd0});
            in_valid_s[k] = 1'b1;
            op_s[k] = OP_ADC;
            a_s[k] = 8'h00;
            b_s[k] = 8'h00;
            repeat (3) begin
                @(posedge clock);
                @(negedge clock);
                check($sformatf("b2b%0d_stall", k), {in_ready_s[k], out_valid_s[k], r_s[k]}, {1'b0, 1'b1, 8'h00});
            end
            out_ready_s[k] = 1'b1;
            #1 check($sformatf("b2b%0d_in_ready", k), 32'(in_ready_s[k]), 32'd1);
            @(posedge clock);
            @(negedge clock);
            in_valid_s[k] = 1'b0;
            out_ready_s[k] = 1'b0;
            check($sformatf("b2b%0d_no_bubble", k), 32'(out_valid_s[k]), 32'd0);
            wait_valid(k, n);
            check($sformatf("b2b%0d_second_latency", k), 32'(n), 32'(steps[k]));
            check($sformatf("b2b%0d_second", k), {20'd0, r_s[k], carry_s[k], 3'd0}, {20'd0, 8'h01, 1'b0, 3'd0});
            handoff(k);
        end

        // Backpressure: DONE held for 10 cycles with in_valid also asserted.
        issue(0, OP_ADD, 8'h7F, 8'h01);
        wait_valid(0, n);
        in_valid_s[0] = 1'b1;
        op_s[0] = OP_SUB;
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
            check("stall_hold", {in_ready_s[0], out_valid_s[0], r_s[0], flags(0)},
                  {1'b0, 1'b1, 8'h80, 4'b0101});
        end
        in_valid_s[0] = 1'b0;
        handoff(0);

        // Set the carry flag, then reset mid-RUN of an ADC.
        issue(0, OP_ADD, 8'hFF, 8'h01);
        wait_valid(0, n);
        check("pre_reset_carry", 32'(carry_s[0]), 32'd1);
        handoff(0);
        issue(0, OP_ADC, 8'h00, 8'h00);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_out_valid", 32'(out_valid_s[0]), 32'd0);
        check("midrun_reset_r_flags", {20'd0, r_s[0], flags(0)}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("post_reset_in_ready", {in_ready_s[0], out_valid_s[0]}, {1'b1, 1'b0});
        @(negedge clock);
        check("post_reset_idle", 32'(out_valid_s[0]), 32'd0);
        issue(0, OP_ADC, 8'h01, 8'h01);
        wait_valid(0, n);
        check("post_reset_adc", {20'd0, r_s[0], flags(0)}, {20'd0, 8'h02, 4'b0000});
        handoff(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
